// File: rtl/usb_pkg.sv
// Shared types and defaults for the CRC16 packet arbiter: FSM state encoding,
// packet/length widths and the legal-length window check.
package usb_pkg;

  localparam int unsigned PKT_W       = 100;
  localparam int unsigned LEN_W       = 32;
  localparam int unsigned MIN_LEN_DEF = 9;
  localparam int unsigned MAX_LEN_DEF = 100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_t;

  // Unsigned 32-bit window test; a length of 0 or all-ones is simply out of range.
  function automatic logic len_legal(input logic [LEN_W-1:0] len,
                                     input logic [LEN_W-1:0] lo,
                                     input logic [LEN_W-1:0] hi);
    return (len >= lo) && (len <= hi);
  endfunction

endpackage

// File: rtl/crc16_rr_arb2.sv
// Two-way round-robin grant logic. The pointer names the preferred requester
// and flips away from whoever was granted whenever a grant is taken.
module crc16_rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  logic rr_ptr_reg;

  always_comb begin
    gnt_idx = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = rr_ptr_reg;
      default: gnt_idx = 1'b0;
    endcase
  end

  always_comb begin
    gnt = 2'b00;
    if (req != 2'b00) begin
      gnt = gnt_idx ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_reg <= 1'b0;
    end else if (take && (req != 2'b00)) begin
      rr_ptr_reg <= ~gnt_idx;
    end
  end

endmodule

// File: rtl/crc16_pkt_arbiter.sv
// Arbitrates two packet requesters onto one external CRC16 calculator: latches
// the winner's packet, starts the calculator, and waits for crc_done or a timeout.
module crc16_pkt_arbiter
  import usb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MIN_LEN        = MIN_LEN_DEF,
  parameter int unsigned MAX_LEN        = MAX_LEN_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [PKT_W-1:0] req_pkt0,
  input  logic [PKT_W-1:0] req_pkt1,
  input  logic [LEN_W-1:0] req_len0,
  input  logic [LEN_W-1:0] req_len1,
  input  logic             crc_done,
  output logic [1:0]       gnt,
  output logic [PKT_W-1:0] pkt_out,
  output logic [LEN_W-1:0] len_out,
  output logic             pkt_ready,
  output logic [1:0]       done,
  output logic [1:0]       err,
  output logic             busy,
  output logic             owner
);

  localparam int unsigned     TW      = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [LEN_W-1:0] MIN_L  = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L  = LEN_W'(MAX_LEN);
  localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  arb_state_t       state_reg, state_next;
  logic [PKT_W-1:0] pkt_reg;
  logic [LEN_W-1:0] len_reg;
  logic             owner_reg;
  logic [TW-1:0]    timer_reg;

  logic [1:0]       arb_gnt;
  logic             arb_idx;
  logic [1:0]       len_ok;
  logic [PKT_W-1:0] pkt_in [2];
  logic [LEN_W-1:0] len_in [2];
  logic             in_idle;
  logic             grant_legal;
  logic             timeout_hit;
  logic [1:0]       owner_hot;

  assign pkt_in[0] = req_pkt0;
  assign pkt_in[1] = req_pkt1;
  assign len_in[0] = req_len0;
  assign len_in[1] = req_len1;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_len_chk
      assign len_ok[gi] = len_legal(len_in[gi], MIN_L, MAX_L);
    end
  endgenerate

  assign in_idle     = (state_reg == ST_IDLE);
  assign grant_legal = len_ok[arb_idx];
  assign timeout_hit = (timer_reg == TO_LAST);
  assign owner_hot   = owner_reg ? 2'b10 : 2'b01;

  crc16_rr_arb2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .take    (in_idle),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (req != 2'b00) state_next = grant_legal ? ST_LOAD : ST_GAP;
      ST_LOAD: state_next = ST_SEND;
      ST_SEND: if (crc_done || timeout_hit) state_next = ST_GAP;
      ST_GAP:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Packet, length and owner are captured on every grant, including rejected ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_reg   <= '0;
      len_reg   <= '0;
      owner_reg <= 1'b0;
      timer_reg <= '0;
    end else begin
      if (in_idle && (req != 2'b00)) begin
        pkt_reg   <= pkt_in[arb_idx];
        len_reg   <= len_in[arb_idx];
        owner_reg <= arb_idx;
      end
      if (state_reg == ST_LOAD) begin
        timer_reg <= '0;
      end else if ((state_reg == ST_SEND) && (timer_reg != '1)) begin
        timer_reg <= timer_reg + 1'b1;
      end
    end
  end

  // Pulses are suppressed while reset is held so an aborted packet reports nothing.
  always_comb begin
    gnt       = 2'b00;
    err       = 2'b00;
    done      = 2'b00;
    pkt_ready = 1'b0;
    busy      = 1'b0;
    if (!reset) begin
      busy = !in_idle;
      case (state_reg)
        ST_IDLE: begin
          gnt = arb_gnt;
          if ((req != 2'b00) && !grant_legal) err = arb_gnt;
        end
        ST_LOAD: pkt_ready = 1'b1;
        ST_SEND: begin
          if (crc_done)         done = owner_hot;
          else if (timeout_hit) err  = owner_hot;
        end
        default: ;
      endcase
    end
  end

  assign pkt_out = pkt_reg;
  assign len_out = len_reg;
  assign owner   = owner_reg;

endmodule

// File: tb/tb_crc16_pkt_arbiter.sv
// Directed bench for crc16_pkt_arbiter: a table of grant transactions with
// hand-computed outcomes, followed by stray-crc_done and mid-SEND reset sequences.
module tb_crc16_pkt_arbiter;
  import usb_pkg::*;

  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [99:0] req_pkt0, req_pkt1;
  logic [31:0] req_len0, req_len1;
  logic        crc_done;
  logic [1:0]  gnt, done, err;
  logic [99:0] pkt_out;
  logic [31:0] len_out;
  logic        pkt_ready, busy, owner;

  int n_checks = 0;
  int n_fail   = 0;

  crc16_pkt_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_pkt0  (req_pkt0),
    .req_pkt1  (req_pkt1),
    .req_len0  (req_len0),
    .req_len1  (req_len1),
    .crc_done  (crc_done),
    .gnt       (gnt),
    .pkt_out   (pkt_out),
    .len_out   (len_out),
    .pkt_ready (pkt_ready),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .owner     (owner)
  );

  always #5 clock = ~clock;

  // crc_at: cycle offset from the grant at which crc_done pulses; 0 = withheld.
  typedef struct {
    logic [1:0]  req;
    logic [31:0] len0;
    logic [31:0] len1;
    int          crc_at;
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_err_g;
    logic [1:0]  exp_done;
    logic [1:0]  exp_err_f;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [99:0] mk_pkt(input int idx, input int who);
    return {36'(idx + 1), 32'hC0DE_0000 | 32'(who), 32'(idx * 7 + who)};
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    logic [99:0] exp_pkt;
    logic [31:0] exp_len;
    int          end_c;
    req      = v.req;
    req_len0 = v.len0;
    req_len1 = v.len1;
    req_pkt0 = mk_pkt(idx, 0);
    req_pkt1 = mk_pkt(idx, 1);
    crc_done = 1'b0;
    exp_pkt  = v.exp_gnt[1] ? req_pkt1 : req_pkt0;
    exp_len  = v.exp_gnt[1] ? req_len1 : req_len0;
    @(negedge clock);
    check("idle_busy", busy, 1'b0);
    check("gnt", gnt, v.exp_gnt);
    check("grant_err", err, v.exp_err_g);
    next_cycle();
    @(negedge clock);
    check("pkt_out", pkt_out, exp_pkt);
    check("len_out", len_out, exp_len);
    check("owner", owner, v.exp_gnt[1]);
    check("pkt_ready", pkt_ready, (v.exp_err_g == 2'b00));
    check("post_grant", {busy, gnt}, 3'b100);
    if (v.exp_err_g == 2'b00) begin
      end_c = (v.crc_at == 0) ? TO + 1 : v.crc_at;
      for (int c = 2; c <= end_c; c++) begin
        next_cycle();
        crc_done = (c == v.crc_at);
        @(negedge clock);
        if (c < end_c) begin
          check("send_quiet", {gnt, pkt_ready, done, err}, 7'b0);
        end else begin
          check("done", done, v.exp_done);
          check("final_err", err, v.exp_err_f);
        end
      end
      next_cycle();
      crc_done = 1'b0;
      @(negedge clock);
      check("gap", {busy, gnt, pkt_ready, done, err}, 8'b1000_0000);
    end
    next_cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    //        req    len0          len1          crc  gnt    err_g  done   err_f
    tbl[0]  = '{2'b11, 32'd24,  32'd40,        12, 2'b01, 2'b00, 2'b01, 2'b00};
    tbl[1]  = '{2'b11, 32'd24,  32'd40,         2, 2'b10, 2'b00, 2'b10, 2'b00};
    tbl[2]  = '{2'b11, 32'd24,  32'd40,        17, 2'b01, 2'b00, 2'b01, 2'b00};
    tbl[3]  = '{2'b11, 32'd24,  32'd40,         0, 2'b10, 2'b00, 2'b00, 2'b10};
    tbl[4]  = '{2'b10, 32'd24,  32'd5,          0, 2'b10, 2'b10, 2'b00, 2'b00};
    tbl[5]  = '{2'b10, 32'd24,  32'd101,        0, 2'b10, 2'b10, 2'b00, 2'b00};
    tbl[6]  = '{2'b01, 32'd9,   32'd24,         5, 2'b01, 2'b00, 2'b01, 2'b00};
    tbl[7]  = '{2'b10, 32'd24,  32'd100,        5, 2'b10, 2'b00, 2'b10, 2'b00};
    tbl[8]  = '{2'b11, 32'd0,   32'd24,         0, 2'b01, 2'b01, 2'b00, 2'b00};
    tbl[9]  = '{2'b11, 32'd24,  32'hFFFF_FFFF,  0, 2'b10, 2'b10, 2'b00, 2'b00};
    tbl[10] = '{2'b11, 32'd100, 32'd9,          0, 2'b01, 2'b00, 2'b00, 2'b01};
    tbl[11] = '{2'b11, 32'd8,   32'd9,          3, 2'b10, 2'b00, 2'b10, 2'b00};
    tbl[12] = '{2'b01, 32'd8,   32'd9,          0, 2'b01, 2'b01, 2'b00, 2'b00};

    reset    = 1'b1;
    req      = 2'b00;
    req_pkt0 = '0;
    req_pkt1 = '0;
    req_len0 = '0;
    req_len1 = '0;
    crc_done = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clock);
    check("reset_state", {gnt, pkt_ready, done, err, busy, owner}, 9'b0);
    check("reset_pkt_len", {pkt_out, len_out}, 132'b0);
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    check("idle_after_reset", {gnt, pkt_ready, done, err, busy}, 8'b0);
    next_cycle();

    for (int i = 0; i < 13; i++) begin
      run_vec(tbl[i], i);
      $display("vector %0d: req=%b len0=%0d len1=%0d -> expected gnt=%b done=%b err=%b/%b",
               i, tbl[i].req, tbl[i].len0, tbl[i].len1,
               tbl[i].exp_gnt, tbl[i].exp_done, tbl[i].exp_err_g, tbl[i].exp_err_f);
    end
    req = 2'b00;
    @(negedge clock);
    check("idle_after_table", busy, 1'b0);

    // Stray crc_done while idle must not produce any response.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      crc_done = 1'b1;
      @(negedge clock);
      check("stray_crc_done", {gnt, pkt_ready, done, err, busy}, 8'b0);
    end
    next_cycle();
    crc_done = 1'b0;
    $display("stray crc_done in IDLE: expected no response");

    // Reset part-way through SEND, then contention must restart at requester 0.
    req      = 2'b01;
    req_len0 = 32'd24;
    req_pkt0 = mk_pkt(20, 0);
    @(negedge clock);
    check("rst_seq_gnt", gnt, 2'b01);
    next_cycle();
    req = 2'b00;
    @(negedge clock);
    check("rst_seq_ready", pkt_ready, 1'b1);
    for (int i = 0; i < 5; i++) next_cycle();
    @(negedge clock);
    check("rst_seq_in_send", {busy, done, err}, 5'b10000);
    next_cycle();
    reset    = 1'b1;
    req      = 2'b11;
    req_len1 = 32'd24;
    next_cycle();
    crc_done = 1'b1;
    @(negedge clock);
    check("rst_outputs", {gnt, pkt_ready, done, err, busy, owner}, 9'b0);
    check("rst_pkt_len", {pkt_out, len_out}, 132'b0);
    next_cycle();
    reset    = 1'b0;
    crc_done = 1'b0;
    @(negedge clock);
    check("post_rst_gnt", gnt, 2'b01);
    check("post_rst_err", err, 2'b00);
    next_cycle();
    req = 2'b00;
    @(negedge clock);
    check("post_rst_ready", pkt_ready, 1'b1);
    next_cycle();
    crc_done = 1'b1;
    @(negedge clock);
    check("post_rst_done", done, 2'b01);
    next_cycle();
    crc_done = 1'b0;
    next_cycle();
    @(negedge clock);
    check("post_rst_idle", busy, 1'b0);
    $display("mid-SEND reset: expected outputs cleared, first grant to requester 0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
